// File: rtl/mem_access_ctrl.sv
// Serialises instruction and data cache requests onto a single-ported RAM; data wins ties unless it won last time.
// Optional MEMCTL_PERF_EN adds icount/dcount completed-access counters.
module mem_access_ctrl #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              iwait,
  output logic              dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
`ifdef MEMCTL_PERF_EN
  ,
  output logic [31:0]       icount,
  output logic [31:0]       dcount
`endif
);

  typedef enum logic [1:0] {IDLE, IFETCH, DACC} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  state_t            state, next_state;
  logic              last_d;
  logic              i_done, d_done;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_store;
  logic              req_wr;

  always_comb begin
    next_state = state;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    case (state)
      IDLE: begin
        // last_d blocks a second consecutive data grant while a fetch waits
        if ((dREN || dWEN) && !(last_d && iREN))
          next_state = DACC;
        else if (iREN)
          next_state = IFETCH;
      end
      DACC: begin
        ramWEN   = req_wr;
        ramREN   = !req_wr;
        ramaddr  = req_addr;
        ramstore = req_store;
        if (!dREN && !dWEN) begin
          next_state = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          dwait      = 1'b0;
          dload      = req_wr ? '0 : ramload;
          d_done     = 1'b1;
          next_state = IDLE;
        end else if (ramstate == RAM_ERROR) begin
          next_state = IDLE;
        end
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = req_addr;
        if (!iREN) begin
          next_state = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          iwait      = 1'b0;
          iload      = ramload;
          i_done     = 1'b1;
          next_state = IDLE;
        end else if (ramstate == RAM_ERROR) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state <= next_state;
      if (d_done)
        last_d <= 1'b1;
      else if (i_done)
        last_d <= 1'b0;
    end
  end

  // Request capture on grant; these only feed the RAM while state is not IDLE, so they carry no reset
  always_ff @(posedge CLK) begin
    if (state == IDLE && next_state == DACC) begin
      req_addr  <= daddr;
      req_store <= dstore;
      req_wr    <= dWEN;
    end else if (state == IDLE && next_state == IFETCH) begin
      req_addr  <= iaddr;
      req_store <= '0;
      req_wr    <= 1'b0;
    end
  end

`ifdef MEMCTL_PERF_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      icount <= '0;
      dcount <= '0;
    end else begin
      if (i_done) icount <= icount + 32'd1;
      if (d_done) dcount <= dcount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a scoreboard queue holds expected completions, a behavioural RAM
// answers BUSY/ERROR/ACCESS on request.
module tb_mem_access_ctrl;
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
`ifdef MEMCTL_PERF_EN
  logic [31:0] icount, dcount;
`endif

  int checks = 0, failures = 0, comp_cnt = 0;
  int busy_cfg = 0, busy_cnt = 0, err_req = 0, err_done = 0;
  logic [31:0] ovr_addr = 32'hFFFF_FFFF, ovr_data = '0;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  mem_access_ctrl #(.WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef MEMCTL_PERF_EN
    , .icount(icount), .dcount(dcount)
`endif
  );

  always #5 CLK = ~CLK;

  // RAM model: each enabled access spends busy_cfg cycles BUSY, then one ERROR per pending err_req, then ACCESS
  wire ram_en = ramREN | ramWEN;
  assign ramstate = !ram_en ? 2'd0 : (busy_cnt != 0) ? 2'd1 : (err_req != err_done) ? 2'd3 : 2'd2;
  assign ramload  = (ramaddr == ovr_addr) ? ovr_data : (ramaddr ^ KEY);

  always @(posedge CLK) begin
    if (!ram_en)
      busy_cnt <= busy_cfg;
    else if (busy_cnt != 0)
      busy_cnt <= busy_cnt - 1;
    else if (err_req != err_done)
      err_done <= err_done + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input int target);
    int c = 0;
    while (comp_cnt < target && c < 60) begin
      @(negedge CLK);
      #1;
      c++;
    end
    check("completion_count", 32'(comp_cnt), 32'(target));
    step();
  endtask

  initial begin
    int base;

    fork
      forever begin
        exp_t e;
        @(negedge CLK);
        if (!iwait || !dwait) begin
          check("single_wait_low", 32'(!iwait && !dwait), 32'd0);
          comp_cnt++;
          check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("kind_is_data", 32'(!dwait), 32'(e.is_d));
            check(e.is_d ? "dload" : "iload", e.is_d ? dload : iload, e.data);
          end
        end
      end
    join_none

    // Reset state
    step(); step();
    @(negedge CLK);
    check("rst_iwait", 32'(iwait), 32'd1);
    check("rst_dwait", 32'(dwait), 32'd1);
    check("rst_ram_en", 32'({ramREN, ramWEN}), 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_loads", iload | dload, 32'd0);
`ifdef MEMCTL_PERF_EN
    check("rst_counts", icount | dcount, 32'd0);
`endif
    step();
    nRST = 1'b1;
    step();

    // 1: instruction fetch answered immediately
    busy_cfg = 0; ovr_addr = 32'h40; ovr_data = 32'h2402000A;
    iREN = 1'b1; iaddr = 32'h40;
    sb.push_back('{is_d: 1'b0, data: 32'h2402000A});
    @(negedge CLK);
    check("s1_idle_no_ren", 32'(ramREN), 32'd0);
    check("s1_idle_iwait", 32'(iwait), 32'd1);
    step();
    @(negedge CLK);
    check("s1_iwait_low", 32'(iwait), 32'd0);
    check("s1_ramaddr", ramaddr, 32'h40);
    check("s1_ramREN", 32'(ramREN), 32'd1);
    step();
    iREN = 1'b0;
    @(negedge CLK);
    check("s1_iwait_one_cycle", 32'(iwait), 32'd1);
    step();

    // 2: data write with three BUSY cycles
    busy_cfg = 3;
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEADBEEF;
    sb.push_back('{is_d: 1'b1, data: 32'h0});
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      check("s2_ramWEN", 32'(ramWEN), 32'(k > 1));
      check("s2_dwait", 32'(dwait), 32'(k != 5));
      if (k > 1) begin
        check("s2_ramstore", ramstore, 32'hDEADBEEF);
        check("s2_ramaddr", ramaddr, 32'h80);
        check("s2_ramREN", 32'(ramREN), 32'd0);
      end
      step();
    end
    dWEN = 1'b0;
    step();

    // 4: data read hits one ERROR, retried, then completes
    busy_cfg = 0; ovr_addr = 32'h100; ovr_data = 32'h1234;
    err_req = err_req + 1;
    base = comp_cnt;
    dREN = 1'b1; daddr = 32'h100;
    sb.push_back('{is_d: 1'b1, data: 32'h1234});
    step();
    @(negedge CLK);
    check("s4_ramstate_error", 32'(ramstate), 32'd3);
    check("s4_no_dwait_on_error", 32'(dwait), 32'd1);
    step();
    @(negedge CLK);
    check("s4_idle_after_error", 32'(ramREN), 32'd0);
    wait_done(base + 1);
    dREN = 1'b0;
    step();

    // 5: fetch withdrawn while BUSY, data request takes over
    busy_cfg = 5;
    base = comp_cnt;
    iREN = 1'b1; iaddr = 32'h200;
    step();
    @(negedge CLK);
    check("s5_fetch_busy_ren", 32'(ramREN), 32'd1);
    step();
    step();
    iREN = 1'b0; dREN = 1'b1; daddr = 32'h300; busy_cfg = 0;
    sb.push_back('{is_d: 1'b1, data: 32'h300 ^ KEY});
    @(negedge CLK);
    check("s5_abort_cycle_iwait", 32'(iwait), 32'd1);
    step();
    @(negedge CLK);
    check("s5_after_abort_en", 32'({ramREN, ramWEN}), 32'd0);
    wait_done(base + 1);
    dREN = 1'b0;
    step();

    // Reset between scenarios so the tie-break starts from data
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    step();

    // 3: simultaneous requests held through four completions
    base = comp_cnt;
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h400; daddr = 32'h500; busy_cfg = 0;
    sb.push_back('{is_d: 1'b1, data: 32'h500 ^ KEY});
    sb.push_back('{is_d: 1'b0, data: 32'h400 ^ KEY});
    sb.push_back('{is_d: 1'b1, data: 32'h500 ^ KEY});
    sb.push_back('{is_d: 1'b0, data: 32'h400 ^ KEY});
    wait_done(base + 4);
    iREN = 1'b0; dREN = 1'b0;
    step();
`ifdef MEMCTL_PERF_EN
    @(negedge CLK);
    check("perf_icount", icount, 32'd2);
    check("perf_dcount", dcount, 32'd2);
    step();
`endif

    // 6: reset asserted mid-access
    busy_cfg = 4;
    base = comp_cnt;
    dREN = 1'b1; daddr = 32'h600;
    step();
    @(negedge CLK);
    check("s6_dacc_ren", 32'(ramREN), 32'd1);
    step();
    nRST = 1'b0;
    @(negedge CLK);
    check("s6_reset_edge_pending", 32'(ramREN), 32'd1);
    step();
    @(negedge CLK);
    check("s6_reset_en", 32'({ramREN, ramWEN}), 32'd0);
    check("s6_reset_waits", 32'({iwait, dwait}), 32'd3);
    check("s6_reset_ramaddr", ramaddr, 32'd0);
`ifdef MEMCTL_PERF_EN
    check("s6_reset_counts", icount | dcount, 32'd0);
`endif
    step();
    dREN = 1'b0; nRST = 1'b1;
    step(); step(); step();
    check("s6_no_completion", 32'(comp_cnt), 32'(base));
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
